periph_bus_arbiter: RTL

Shares the single peripheral bus (ROM / stack RAM / GPIO address decoder) between two requesters: M0 = core load/store port, M1 = program loader/debug port. The arbiter grants one master at a time (round-robin on contention) and latches that master's request. It drives the bus for a region-dependent number of wait states, then returns read data with a one-cycle ack. It sits between the masters and the address decoder's Adr/MemWrite/MemRead/Data inputs.

---
 rtl/periph_bus_pkg.sv | 23 ++
 rtl/periph_region_classify.sv | 20 ++
 rtl/periph_bus_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter.
// Region map constants match the address decoder.
package periph_bus_pkg;

   localparam logic [15:0] TEXT_HI    = 16'h0040;
   localparam logic [15:0] GPIO_1     = 16'h0024;
   localparam logic [15:0] GPIO_2     = 16'h0028;
   localparam logic [31:0] STACK_BASE = 32'h7735_9400;

   typedef enum logic [1:0] {
      REG_ROM,
      REG_GPIO,
      REG_STACK,
      REG_NONE
   } region_e;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_e;

endpackage

// File: rtl/periph_region_classify.sv
// Combinational address-to-region map.
// Priority ROM > GPIO > STACK > unmapped, same as the decoder.
module periph_region_classify
   import periph_bus_pkg::*;
(
   input  logic [31:0] i_addr,
   output region_e     o_region
);

   always_comb begin
      o_region = REG_NONE;
      if (i_addr[31:16] == TEXT_HI)
         o_region = REG_ROM;
      else if (i_addr[15:0] == GPIO_1 || i_addr[15:0] == GPIO_2)
         o_region = REG_GPIO;
      else if (i_addr >= STACK_BASE)
         o_region = REG_STACK;
   end

endmodule

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the peripheral bus.
// One access at a time with region-dependent wait states.
module periph_bus_arbiter
   import periph_bus_pkg::*;
#(
   parameter int WAIT_ROM   = 1,
   parameter int WAIT_STACK = 2,
   parameter int WAIT_GPIO  = 0,
   parameter int CNT_W      = 4
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic        m0_ack,
   output logic        m0_err,
   output logic        m1_ack,
   output logic        m1_err,
   output logic [31:0] m_rdata,
   output logic [31:0] bus_adr,
   output logic        bus_we,
   output logic        bus_re,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   output logic        busy
);

   state_e           r_state;
   state_e           w_next;
   region_e          w_region;
   logic             w_any;
   logic             w_sel;
   logic [31:0]      w_sel_addr;
   logic [CNT_W-1:0] w_load;
   logic             w_access;
   logic             w_resp;

   logic             r_last_gnt;
   logic             r_gnt;
   logic             r_we;
   logic             r_err;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [31:0]      r_rdata;
   logic [CNT_W-1:0] r_cnt;

   // On a tie the master that did not win last time is chosen
   assign w_any      = m0_req | m1_req;
   assign w_sel      = m1_req & (~m0_req | ~r_last_gnt);
   assign w_sel_addr = w_sel ? m1_addr : m0_addr;

   periph_region_classify u_classify (
      .i_addr   (w_sel_addr),
      .o_region (w_region)
   );

   always_comb begin
      w_load = '0;
      case (w_region)
         REG_ROM:   w_load = CNT_W'(WAIT_ROM);
         REG_GPIO:  w_load = CNT_W'(WAIT_GPIO);
         REG_STACK: w_load = CNT_W'(WAIT_STACK);
         default:   w_load = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_any) w_next = ACCESS;
         ACCESS:  if (r_cnt == '0) w_next = RESP;
         RESP:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_gnt <= 1'b1;
         r_gnt      <= 1'b0;
         r_we       <= 1'b0;
         r_err      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_sel;
                  r_addr  <= w_sel_addr;
                  r_we    <= w_sel ? m1_we : m0_we;
                  r_wdata <= w_sel ? m1_wdata : m0_wdata;
                  r_err   <= (w_region == REG_NONE);
                  r_cnt   <= w_load;
               end
            end
            ACCESS: begin
               if (r_cnt != '0)
                  r_cnt <= r_cnt - 1'b1;
               else
                  r_rdata <= (r_we | r_err) ? '0 : bus_rdata;
            end
            RESP:    r_last_gnt <= r_gnt;
            default: ;
         endcase
      end
   end

   assign w_access  = (r_state == ACCESS);
   assign w_resp    = (r_state == RESP);

   assign bus_adr   = w_access ? r_addr  : '0;
   assign bus_wdata = w_access ? r_wdata : '0;
   assign bus_re    = w_access & ~r_we & ~r_err;
   assign bus_we    = w_access &  r_we & ~r_err;

   assign m0_ack    = w_resp & ~r_gnt;
   assign m1_ack    = w_resp &  r_gnt;
   assign m0_err    = m0_ack & r_err;
   assign m1_err    = m1_ack & r_err;
   assign m_rdata   = r_rdata;
   assign busy      = (r_state != IDLE);

endmodule
